mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 19 +
 rtl/mem_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_arbiter.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and widths for the two-port memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  // Owner encoding; also the FSM state encoding and the debug owner output.
  localparam logic [1:0] OWN_IDLE = 2'd0;
  localparam logic [1:0] OWN_I    = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;

  typedef enum logic [1:0] {
    StIdle = OWN_IDLE,
    StOwnI = OWN_I,
    StOwnD = OWN_D
  } state_e;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-refill port and a data port onto one shared memory port.
// Instruction grants last a burst of BURST_LEN beats (or until the requester goes quiet
// for GAP_MAX cycles); data grants last exactly one beat. Ties alternate.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned GAP_MAX   = 2
) (
  input  logic              clk,
  input  logic              reset,
  // Instruction refill port (read only)
  input  logic              i_valid,
  output logic              i_ready,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  // Data port
  input  logic              d_valid,
  output logic              d_ready,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [STRB_W-1:0] d_wstrb,
  output logic [DATA_W-1:0] d_rdata,
  // Shared memory port
  output logic              mem_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [STRB_W-1:0] mem_wstrb,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  // Debug
  output logic [1:0]        owner
);

  localparam int unsigned BeatW = $clog2(BURST_LEN + 1);
  localparam int unsigned GapW  = $clog2(GAP_MAX + 1);
  localparam logic [BeatW-1:0] BeatLast = BeatW'(BURST_LEN - 1);
  localparam logic [GapW-1:0]  GapLast  = GapW'(GAP_MAX - 1);

  state_e           state_q, state_d;
  logic [BeatW-1:0] beat_cnt_q, beat_cnt_d;
  logic [GapW-1:0]  gap_cnt_q, gap_cnt_d;
  logic [1:0]       last_owner_q, last_owner_d;
  logic             beat;

  // Steer the owning requester onto the memory port; idle drives all zeros.
  always_comb begin
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    unique case (state_q)
      StOwnI: begin
        mem_valid = i_valid;
        mem_addr  = i_addr;
      end
      StOwnD: begin
        mem_valid = d_valid;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        mem_wstrb = d_wstrb;
      end
      default: ;
    endcase
  end

  // A beat needs mem_valid, so a stray mem_ready in idle or during a gap is ignored.
  always_comb begin
    beat    = mem_valid & mem_ready;
    i_ready = beat & (state_q == StOwnI);
    d_ready = beat & (state_q == StOwnD);
    i_rdata = mem_rdata;
    d_rdata = mem_rdata;
    owner   = state_q;
  end

  // Grant, burst/gap counting and release.
  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    last_owner_d = last_owner_q;
    unique case (state_q)
      StIdle: begin
        // Counters start fresh on every grant.
        beat_cnt_d = '0;
        gap_cnt_d  = '0;
        if (i_valid && d_valid) begin
          state_d = (last_owner_q == OWN_I) ? StOwnD : StOwnI;
        end else if (i_valid) begin
          state_d = StOwnI;
        end else if (d_valid) begin
          state_d = StOwnD;
        end
      end
      StOwnI: begin
        if (beat) begin
          beat_cnt_d = beat_cnt_q + BeatW'(1);
        end
        gap_cnt_d = i_valid ? '0 : gap_cnt_q + GapW'(1);
        // Release on the final beat or when the refill is abandoned.
        if ((beat && beat_cnt_q == BeatLast) || (!i_valid && gap_cnt_q == GapLast)) begin
          state_d      = StIdle;
          last_owner_d = OWN_I;
        end
      end
      StOwnD: begin
        // The data port never abandons: hold until its single beat completes.
        if (beat) begin
          state_d      = StIdle;
          last_owner_d = OWN_D;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; data starts as last owner so instruction wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      beat_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      last_owner_q <= OWN_D;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      last_owner_q <= last_owner_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int BurstLen = 4;
  localparam int GapMax   = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_valid, i_ready, d_valid, d_ready, mem_valid, mem_ready;
  logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  d_wstrb, mem_wstrb;
  logic [1:0]  owner;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(
    .BURST_LEN(BurstLen),
    .GAP_MAX  (GapMax)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .i_valid  (i_valid),
    .i_ready  (i_ready),
    .i_addr   (i_addr),
    .i_rdata  (i_rdata),
    .d_valid  (d_valid),
    .d_ready  (d_ready),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_wstrb  (d_wstrb),
    .d_rdata  (d_rdata),
    .mem_valid(mem_valid),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .owner    (owner)
  );

  always #5 clk = ~clk;

  // Reference model: who holds the memory, beats delivered, idle run length, last holder.
  int m_own;   // 0 nobody, 1 instruction, 2 data
  int m_beats;
  int m_gap;
  int m_last;

  always @(posedge clk) begin
    if (reset) begin
      m_own   <= 0;
      m_beats <= 0;
      m_gap   <= 0;
      m_last  <= 2;
    end else if (m_own == 0) begin
      m_beats <= 0;
      m_gap   <= 0;
      if (i_valid && d_valid) m_own <= (m_last == 1) ? 2 : 1;
      else if (i_valid)       m_own <= 1;
      else if (d_valid)       m_own <= 2;
    end else if (m_own == 1) begin
      if (i_valid && mem_ready) m_beats <= m_beats + 1;
      m_gap <= i_valid ? 0 : m_gap + 1;
      if (m_beats + ((i_valid && mem_ready) ? 1 : 0) == BurstLen ||
          (!i_valid && m_gap + 1 == GapMax)) begin
        m_own  <= 0;
        m_last <= 1;
      end
    end else begin
      if (d_valid && mem_ready) begin
        m_own  <= 0;
        m_last <= 2;
      end
    end
  end

  logic        exp_mv, exp_ir, exp_dr;
  logic [31:0] exp_addr, exp_wdata;
  logic [3:0]  exp_wstrb;
  logic [136:0] exp_vec, got_vec;

  always_comb begin
    exp_mv    = 1'b0;
    exp_addr  = '0;
    exp_wdata = '0;
    exp_wstrb = '0;
    exp_ir    = 1'b0;
    exp_dr    = 1'b0;
    if (m_own == 1) begin
      exp_mv   = i_valid;
      exp_addr = i_addr;
      exp_ir   = i_valid && mem_ready;
    end else if (m_own == 2) begin
      exp_mv    = d_valid;
      exp_addr  = d_addr;
      exp_wdata = d_wdata;
      exp_wstrb = d_wstrb;
      exp_dr    = d_valid && mem_ready;
    end
    exp_vec = {exp_mv, exp_addr, exp_wdata, exp_wstrb, exp_ir, exp_dr, 2'(m_own),
               mem_rdata, mem_rdata};
    got_vec = {mem_valid, mem_addr, mem_wdata, mem_wstrb, i_ready, d_ready, owner,
               i_rdata, d_rdata};
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_valid   = 1'b0;
    i_addr    = '0;
    d_valid   = 1'b0;
    d_addr    = '0;
    d_wdata   = '0;
    d_wstrb   = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    i_valid   = 1'b1;
    i_addr    = 32'h40;
    d_valid   = 1'b1;
    d_addr    = 32'h100;
    d_wstrb   = 4'hF;
    mem_ready = 1'b1;
    reset     = 1'b1;
    next_cycle();
    next_cycle();
    #3;
    checks++;
    if ({mem_valid, i_ready, d_ready, owner, mem_wstrb} !== 9'b0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b ir=%b dr=%b own=%0d strb=%h want all zero",
               mem_valid, i_ready, d_ready, owner, mem_wstrb);
    end
    checks++;
    if ({mem_addr, mem_wdata} !== 64'h0) begin
      errors++;
      $display("FAIL reset_addr: got addr=%h wdata=%h want 0", mem_addr, mem_wdata);
    end
    reset = 1'b0;
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_lone_write();
    do_reset();
    d_valid = 1'b1;
    d_addr  = 32'h100;
    d_wdata = 32'hA5A5_0001;
    d_wstrb = 4'hF;
    #3;
    checks++;
    if (owner !== 2'd0 || mem_valid !== 1'b0) begin
      errors++;
      $display("FAIL write_arb_cycle: got own=%0d v=%b want own=0 v=0", owner, mem_valid);
    end
    next_cycle();
    #3;
    checks++;
    if ({owner, mem_valid, d_ready, mem_addr} !== {2'd2, 1'b1, 1'b0, 32'h100}) begin
      errors++;
      $display("FAIL write_grant: got own=%0d v=%b dr=%b addr=%h want 2 1 0 100",
               owner, mem_valid, d_ready, mem_addr);
    end
    next_cycle();
    mem_ready = 1'b1;
    mem_rdata = 32'h1234_5678;
    #3;
    checks++;
    if ({d_ready, i_ready, mem_addr, mem_wdata, mem_wstrb} !==
        {1'b1, 1'b0, 32'h100, 32'hA5A5_0001, 4'hF}) begin
      errors++;
      $display("FAIL write_beat: got dr=%b ir=%b addr=%h wd=%h strb=%h want 1 0 100 a5a50001 f",
               d_ready, i_ready, mem_addr, mem_wdata, mem_wstrb);
    end
    next_cycle();
    idle_inputs();
    #3;
    checks++;
    if (owner !== 2'd0 || d_ready !== 1'b0) begin
      errors++;
      $display("FAIL write_release: got own=%0d dr=%b want 0 0", owner, d_ready);
    end
  endtask

  task automatic test_refill_burst();
    do_reset();
    i_valid = 1'b1;
    i_addr  = 32'h40;
    d_addr  = 32'h200;
    next_cycle();
    for (int k = 0; k < 4; k++) begin
      i_valid   = 1'b1;
      i_addr    = 32'h40 + 32'(4 * k);
      mem_ready = 1'b1;
      mem_rdata = $urandom;
      if (k >= 1) d_valid = 1'b1;
      #3;
      checks++;
      if ({i_ready, d_ready, owner, mem_addr, i_rdata} !==
          {1'b1, 1'b0, 2'd1, 32'h40 + 32'(4 * k), mem_rdata}) begin
        errors++;
        $display("FAIL refill_beat%0d: got ir=%b dr=%b own=%0d addr=%h rd=%h want 1 0 1 %h %h",
                 k, i_ready, d_ready, owner, mem_addr, i_rdata, 32'h40 + 32'(4 * k), mem_rdata);
      end
      next_cycle();
      if (k < 3) begin
        i_valid = 1'b0;
        #3;
        checks++;
        if ({owner, mem_valid, i_ready, d_ready} !== {2'd1, 3'b000}) begin
          errors++;
          $display("FAIL refill_gap%0d: got own=%0d v=%b ir=%b dr=%b want 1 0 0 0",
                   k, owner, mem_valid, i_ready, d_ready);
        end
        next_cycle();
      end
    end
    i_valid   = 1'b0;
    mem_ready = 1'b0;
    #3;
    checks++;
    if (owner !== 2'd0 || mem_valid !== 1'b0) begin
      errors++;
      $display("FAIL refill_idle_gap: got own=%0d v=%b want 0 0", owner, mem_valid);
    end
    next_cycle();
    mem_ready = 1'b1;
    #3;
    checks++;
    if ({owner, mem_addr, d_ready} !== {2'd2, 32'h200, 1'b1}) begin
      errors++;
      $display("FAIL refill_then_d: got own=%0d addr=%h dr=%b want 2 200 1",
               owner, mem_addr, d_ready);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_tie();
    logic [1:0] exp_own [9];
    exp_own = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1};
    do_reset();
    i_valid   = 1'b1;
    i_addr    = 32'h80;
    d_valid   = 1'b1;
    d_addr    = 32'h300;
    mem_ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      #3;
      checks++;
      if (owner !== exp_own[c]) begin
        errors++;
        $display("FAIL tie_owner_c%0d: got %0d want %0d", c, owner, exp_own[c]);
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_abandon();
    logic [1:0] exp_own [7];
    exp_own = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd2};
    do_reset();
    i_valid   = 1'b1;
    i_addr    = 32'h40;
    d_addr    = 32'h400;
    mem_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      if (c == 2) begin
        d_valid = 1'b1;
        i_addr  = 32'h44;
      end
      if (c == 3) i_valid = 1'b0;
      #3;
      checks++;
      if (owner !== exp_own[c]) begin
        errors++;
        $display("FAIL abandon_owner_c%0d: got %0d want %0d", c, owner, exp_own[c]);
      end
      if (c == 3 || c == 4) begin
        checks++;
        if ({mem_valid, i_ready, d_ready} !== 3'b000) begin
          errors++;
          $display("FAIL abandon_gap_c%0d: got v=%b ir=%b dr=%b want 0 0 0",
                   c, mem_valid, i_ready, d_ready);
        end
      end
      if (c == 6) begin
        checks++;
        if ({mem_addr, d_ready} !== {32'h400, 1'b1}) begin
          errors++;
          $display("FAIL abandon_d_grant: got addr=%h dr=%b want 400 1", mem_addr, d_ready);
        end
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    i_valid   = 1'b1;
    i_addr    = 32'h40;
    mem_ready = 1'b1;
    next_cycle();
    next_cycle();
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    #3;
    checks++;
    if ({mem_valid, owner, i_ready, d_ready} !== 5'b0) begin
      errors++;
      $display("FAIL midreset_drop: got v=%b own=%0d ir=%b dr=%b want all zero",
               mem_valid, owner, i_ready, d_ready);
    end
    next_cycle();
    for (int k = 0; k < 4; k++) begin
      #3;
      checks++;
      if (owner !== 2'd1 || i_ready !== 1'b1) begin
        errors++;
        $display("FAIL midreset_beat%0d: got own=%0d ir=%b want 1 1", k, owner, i_ready);
      end
      next_cycle();
    end
    i_valid = 1'b0;
    #3;
    checks++;
    if (owner !== 2'd0) begin
      errors++;
      $display("FAIL midreset_release: got own=%0d want 0", owner);
    end
    idle_inputs();
  endtask

  task automatic test_spurious_ready();
    do_reset();
    mem_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      mem_rdata = $urandom;
      #3;
      checks++;
      if ({i_ready, d_ready, owner, mem_valid} !== 5'b0 || i_rdata !== mem_rdata) begin
        errors++;
        $display("FAIL spurious_c%0d: got ir=%b dr=%b own=%0d v=%b rd=%h want 0 0 0 0 %h",
                 c, i_ready, d_ready, owner, mem_valid, i_rdata, mem_rdata);
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      reset     = ($urandom_range(0, 199) == 0);
      i_valid   = ($urandom_range(0, 99) < 70);
      i_addr    = $urandom;
      d_valid   = ($urandom_range(0, 99) < 35);
      d_addr    = $urandom;
      d_wdata   = $urandom;
      d_wstrb   = 4'($urandom);
      mem_ready = ($urandom_range(0, 99) < 50);
      mem_rdata = $urandom;
      #3;
      checks++;
      if (got_vec !== exp_vec) begin
        errors++;
        $display("FAIL random_c%0d: got %h want %h", c, got_vec, exp_vec);
      end
      next_cycle();
    end
    reset = 1'b0;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_lone_write();
    test_refill_burst();
    test_tie();
    test_abandon();
    test_reset_mid_burst();
    test_spurious_ready();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
